// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding,
// iteration count and the DIV/DIVU function selectors used by the ALU decode.
package div_unit_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = 32;
  localparam int DIV_CNT_W  = 6;

  // Function-field selectors the ALU decode uses to hand a divide to this unit
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_DZERO = 2'd1,
    DIV_ON    = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, try to
// subtract the divisor from the widened remainder and set the quotient bit.
// The shifted remainder needs WIDTH+1 bits because it can reach 2*divisor-1.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] rq_out
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Trial subtraction; keep the difference only when it does not go negative
  always_comb begin
    shifted_s = rq_in[2*WIDTH-1:WIDTH-1];
    trial_s   = shifted_s - {1'b0, divisor};
    if (shifted_s >= {1'b0, divisor}) begin
      rq_out = {trial_s[WIDTH-1:0], rq_in[WIDTH-2:0], 1'b1};
    end else begin
      rq_out = {shifted_s[WIDTH-1:0], rq_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Returns {HI,LO} = {remainder, quotient}; one quotient bit per cycle.
// Optional build macro DIV_FAST_PATH_EN: when |a| < |b| the result
// {a, 0} is produced without iterating (done two cycles after start).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 annul,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   hilo_out
);

  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] ONES_W = '1;
  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_CYCLES - 1);

  // Two's complement negate, wrapping modulo 2^WIDTH
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  div_state_e             state_r;
  logic [DIV_CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0]     rq_r;
  logic [WIDTH-1:0]       divisor_r;
  logic                   quo_neg_r;
  logic                   rem_neg_r;
  logic [2*WIDTH-1:0]     result_r;
  logic [2*WIDTH-1:0]     hilo_r;

  logic [WIDTH-1:0]       a_abs_s;
  logic [WIDTH-1:0]       b_abs_s;
  logic                   fast_s;
  logic [2*WIDTH-1:0]     step_s;
  logic [WIDTH-1:0]       quo_fix_s;
  logic [WIDTH-1:0]       rem_fix_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rq_in   (rq_r),
    .divisor (divisor_r),
    .rq_out  (step_s)
  );

  // Operand magnitudes; unsigned divides use the raw operands
  always_comb begin
    if (signed_div && a[WIDTH-1]) begin
      a_abs_s = twos_neg(a);
    end else begin
      a_abs_s = a;
    end
    if (signed_div && b[WIDTH-1]) begin
      b_abs_s = twos_neg(b);
    end else begin
      b_abs_s = b;
    end
  end

  // Early-out qualifier for dividends smaller than the divisor
  always_comb begin
`ifdef DIV_FAST_PATH_EN
    fast_s = (a_abs_s < b_abs_s);
`else
    fast_s = 1'b0;
`endif
  end

  // Sign fix-up of the final iteration's quotient and remainder
  always_comb begin
    if (quo_neg_r) begin
      quo_fix_s = twos_neg(step_s[WIDTH-1:0]);
    end else begin
      quo_fix_s = step_s[WIDTH-1:0];
    end
    if (rem_neg_r) begin
      rem_fix_s = twos_neg(step_s[2*WIDTH-1:WIDTH]);
    end else begin
      rem_fix_s = step_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= DIV_IDLE;
      cnt_r     <= '0;
      rq_r      <= '0;
      divisor_r <= '0;
      quo_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      result_r  <= '0;
      hilo_r    <= '0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start && !annul) begin
            if (b == ZERO_W) begin
              state_r  <= DIV_DZERO;
              result_r <= {a, ONES_W};
            end else if (fast_s) begin
              // Reuses the one-cycle DZERO pass so done still lands at T+2
              state_r  <= DIV_DZERO;
              result_r <= {a, ZERO_W};
            end else begin
              state_r   <= DIV_ON;
              rq_r      <= {ZERO_W, a_abs_s};
              divisor_r <= b_abs_s;
              quo_neg_r <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
              rem_neg_r <= signed_div & a[WIDTH-1];
              cnt_r     <= '0;
            end
          end else begin
            state_r <= DIV_IDLE;
          end
        end
        DIV_DZERO: begin
          if (annul) begin
            state_r <= DIV_IDLE;
          end else begin
            state_r <= DIV_DONE;
          end
        end
        DIV_ON: begin
          if (annul) begin
            state_r <= DIV_IDLE;
          end else begin
            rq_r  <= step_s;
            cnt_r <= cnt_r + DIV_CNT_W'(1);
            if (cnt_r == LAST_CNT) begin
              state_r  <= DIV_DONE;
              result_r <= {rem_fix_s, quo_fix_s};
            end else begin
              state_r <= DIV_ON;
            end
          end
        end
        DIV_DONE: begin
          if (!annul) begin
            hilo_r <= result_r;
          end else begin
            hilo_r <= hilo_r;
          end
          state_r <= DIV_IDLE;
        end
        default: begin
          state_r <= DIV_IDLE;
        end
      endcase
    end
  end

  // A same-cycle annul must suppress the result, so done/hilo are gated here
  always_comb begin
    done = (state_r == DIV_DONE) && !annul;
    if (done) begin
      hilo_out = result_r;
    end else begin
      hilo_out = hilo_r;
    end
    busy = ((state_r == DIV_IDLE) && start && !annul) ||
           (state_r == DIV_ON) || (state_r == DIV_DZERO);
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider for DIV/DIVU.
- Sits beside the ALU in the EX stage. Consumes the divide operands and signedness the ALU path hands off, and returns {HI,LO} = {remainder, quotient} for the HI/LO register write.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Raises a busy/stall signal to the pipeline while the divide is in progress.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a divide; sampled only in IDLE.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU.
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- annul  in  1  flush/exception cancel; aborts any operation.
- busy  out  1  stall request to the pipeline.
- done  out  1  one-cycle pulse; hilo_out is valid in this cycle.
- hilo_out  out  2*WIDTH  {remainder, quotient}.

Interface (already decided): one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset: state=IDLE; busy=0; done=0; hilo_out=0; all internal registers cleared. A reset mid-operation discards the operation with no done pulse.
- FSM states: IDLE, DZERO, ON, DONE.
- IDLE:
  - start & ~annul & b==0 → DZERO.
  - start & ~annul & b!=0 → ON. Latch |a|, |b|, the sign of a, the sign of a^b (signed mode only), and clear cnt.
  - start & annul → stay in IDLE.
- ON:
  - Each cycle: shift {rem,quo} left by 1, compute trial = rem − |b|, set the quotient bit, increment cnt.
  - After the 32nd step → DONE.
  - Operands are latched at start; changes on a/b/signed_div during ON are ignored.
- DZERO: one cycle, then → DONE. Result is quotient=32'hFFFFFFFF, remainder=a (raw, unmodified).
- DONE:
  - done=1 and hilo_out valid for exactly this cycle.
  - hilo_out holds its value afterwards until the next done.
  - Always → IDLE; start in this cycle is ignored.
- annul in DZERO, ON or DONE: → IDLE next cycle. done is suppressed in that cycle and hilo_out is not updated.
- Latency: start sampled in cycle T → done in cycle T+33 (normal path) or T+2 (divide by zero).
- busy (combinational) = (IDLE & start & ~annul) | ON | DZERO. busy=0 in DONE so the pipeline advances with the result.
- Sign fix-up (signed only):
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Negation is two's complement modulo 2^32.
  - 0x80000000 / −1 → quotient 0x80000000, remainder 0 (wraps, no trap).
- Unsigned: no sign fix-up; |x| = x.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined: in IDLE, if b!=0 and |a| < |b|, go to DONE directly with quotient=0 and remainder=a (raw); done at T+2.
- Undefined: that case takes the full 32-step path, done at T+33, with the same result.

Decomposition:
- defines.vh holds:
  - State encodings DIV_IDLE, DIV_DZERO, DIV_ON, DIV_DONE.
  - DIV_CYCLES = 32.
  - The div/divu opcode selectors already used by the ALU decode.
- One natural combinational sub-module, div_step: inputs {rem,quo} and the divisor; output the next {rem,quo} for one restoring iteration.

Test Plan:
- DIVU a=100, b=7, start at T → busy=1 for T..T+32; done at T+33 only; hilo_out={32'd2, 32'd14}.
- DIV a=0xFFFFFFF9 (−7), b=2 → hilo_out={0xFFFFFFFF, 0xFFFFFFFD} (rem −1, quo −3); check DIV a=7, b=−2 → {1, 0xFFFFFFFD}.
- DIV a=0x80000000, b=0xFFFFFFFF → hilo_out={0, 0x80000000}, done at T+33.
- b=0, a=0x1234 → done at T+2, hilo_out={0x00001234, 0xFFFFFFFF}; busy=1 in T and T+1 only.
- Start DIVU 100/7 at T, annul at T+10 → busy=0 from T+11 with no done. New start (DIVU 9/3) at T+11 → done at T+44, hilo_out={0, 3}. rst at T+5 of any op → all outputs 0 at T+6 and no done.
- DIVU a=3, b=10 → with DIV_FAST_PATH_EN: done T+2, {3,0}. Without: done T+33, {3,0}.
